// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and ALU operand forwarding select values (also consumed by forwardMux).
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/pipe_hazard_unit_fwd_select.sv
// Per-operand forwarding priority: the younger EX/MEM result beats MEM/WB,
// and register $0 is never forwarded.
import hazard_pkg::*;

module fwd_select #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            sel
);

    always_comb begin
        sel = FWD_REG;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Central hazard controller for the 5-stage pipeline: load-use interlock,
// data-memory freeze with watchdog, redirect flushes, forwarding and counters.
import hazard_pkg::*;

module pipe_hazard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_STAGES = 3,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  redirect,
    input  logic                  mem_busy,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  mem_wb_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT + 1);

    hz_state_t         state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              lu, stall_evt, flush_evt;
    logic [1:0]        sel_a, sel_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src(ex_rs), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .sel(sel_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src(ex_rt), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .sel(sel_b)
    );

    assign forward_a = reset ? FWD_REG : sel_a;
    assign forward_b = reset ? FWD_REG : sel_b;

    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (wait_next == WAIT_MAX) mem_err <= 1'b1;
            if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
            if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
        end
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            RUN, LU_STALL: begin
                if (mem_busy) begin
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else if (!redirect && lu && (state == RUN)) begin
                    state_next = LU_STALL;
                end else begin
                    state_next = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    wait_next = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + 1'b1;
                end else begin
                    state_next = RUN;
                    wait_next  = '0;
                end
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase
    end

    // A redirect during a freeze is ignored: the resolving stage re-presents it.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;
        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            stall_evt    = 1'b1;
        end else if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = (FLUSH_STAGES == 3);
            flush_evt    = 1'b1;
        end else if (lu && (state != LU_STALL)) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            stall_evt    = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: default, FLUSH_STAGES=2 and CNT_W=4
// instances share one stimulus stream.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write, redirect, mem_busy;

    logic        pcw_m, ifw_m, idw_m, exw_m, mww_m, iff_m, idf_m, exf_m, err_m;
    logic [1:0]  fa_m, fb_m;
    logic [15:0] sc_m, fc_m;
    logic        pcw_2, ifw_2, idw_2, exw_2, mww_2, iff_2, idf_2, exf_2, err_2;
    logic [1:0]  fa_2, fb_2;
    logic [15:0] sc_2, fc_2;
    logic        pcw_4, ifw_4, idw_4, exw_4, mww_4, iff_4, idf_4, exf_4, err_4;
    logic [1:0]  fa_4, fb_4;
    logic [3:0]  sc_4, fc_4;

    int n_tests = 0;
    int n_fail  = 0;
    int m_stall = 0;
    int m_flush = 0;
    logic m_err = 1'b0;

    typedef struct {
        string      tag;
        logic [4:0] wr;
        logic [2:0] fl;
        logic       fl2_exmem;
        logic [1:0] fa;
        logic [1:0] fb;
        int         stall;
        int         flush;
        logic       err;
    } exp_t;
    exp_t sb[$];

    localparam logic [4:0] W1  = 5'b11111;
    localparam logic [4:0] W0  = 5'b00000;
    localparam logic [4:0] WLU = 5'b00111;
    localparam logic [2:0] F0  = 3'b000;
    localparam logic [2:0] FA  = 3'b111;
    localparam logic [2:0] FLU = 3'b010;

    always #5 clk = ~clk;

    pipe_hazard_unit dut_m (
        .clock_in(clk), .reset(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .redirect(redirect), .mem_busy(mem_busy),
        .pc_write(pcw_m), .if_id_write(ifw_m), .id_ex_write(idw_m), .ex_mem_write(exw_m),
        .mem_wb_write(mww_m), .if_id_flush(iff_m), .id_ex_flush(idf_m), .ex_mem_flush(exf_m),
        .forward_a(fa_m), .forward_b(fb_m), .mem_err(err_m), .stall_cnt(sc_m), .flush_cnt(fc_m)
    );

    pipe_hazard_unit #(.FLUSH_STAGES(2)) dut_2 (
        .clock_in(clk), .reset(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .redirect(redirect), .mem_busy(mem_busy),
        .pc_write(pcw_2), .if_id_write(ifw_2), .id_ex_write(idw_2), .ex_mem_write(exw_2),
        .mem_wb_write(mww_2), .if_id_flush(iff_2), .id_ex_flush(idf_2), .ex_mem_flush(exf_2),
        .forward_a(fa_2), .forward_b(fb_2), .mem_err(err_2), .stall_cnt(sc_2), .flush_cnt(fc_2)
    );

    pipe_hazard_unit #(.CNT_W(4)) dut_4 (
        .clock_in(clk), .reset(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .redirect(redirect), .mem_busy(mem_busy),
        .pc_write(pcw_4), .if_id_write(ifw_4), .id_ex_write(idw_4), .ex_mem_write(exw_4),
        .mem_wb_write(mww_4), .if_id_flush(iff_4), .id_ex_flush(idf_4), .ex_mem_flush(exf_4),
        .forward_a(fa_4), .forward_b(fb_4), .mem_err(err_4), .stall_cnt(sc_4), .flush_cnt(fc_4)
    );

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "/m.ctl"}, 32'({pcw_m, ifw_m, idw_m, exw_m, mww_m, iff_m, idf_m, exf_m, fa_m, fb_m}),
              32'({e.wr, e.fl, e.fa, e.fb}));
        check({e.tag, "/m.stall"}, 32'(sc_m), 32'(sat(e.stall, 16)));
        check({e.tag, "/m.flush"}, 32'(fc_m), 32'(sat(e.flush, 16)));
        check({e.tag, "/m.err"}, 32'(err_m), 32'(e.err));
        check({e.tag, "/fs2.ctl"}, 32'({pcw_2, ifw_2, idw_2, exw_2, mww_2, iff_2, idf_2, exf_2, fa_2, fb_2}),
              32'({e.wr, e.fl[2:1], e.fl2_exmem, e.fa, e.fb}));
        check({e.tag, "/fs2.cnt"}, {sc_2, fc_2}, {16'(sat(e.stall, 16)), 16'(sat(e.flush, 16))});
        check({e.tag, "/fs2.err"}, 32'(err_2), 32'(e.err));
        check({e.tag, "/c4.ctl"}, 32'({pcw_4, ifw_4, idw_4, exw_4, mww_4, iff_4, idf_4, exf_4, fa_4, fb_4}),
              32'({e.wr, e.fl, e.fa, e.fb}));
        check({e.tag, "/c4.stall"}, 32'(sc_4), 32'(sat(e.stall, 4)));
        check({e.tag, "/c4.flush"}, 32'(fc_4), 32'(sat(e.flush, 4)));
        check({e.tag, "/c4.err"}, 32'(err_4), 32'(e.err));
    endtask

    // One cycle: expected combinational outputs plus pre-edge counter state.
    task automatic step(input string tag, input logic [4:0] wr, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input bit inc_s, input bit inc_f);
        exp_t e;
        e.tag = tag; e.wr = wr; e.fl = fl; e.fa = fa; e.fb = fb;
        e.fl2_exmem = fl[0] & rst;
        e.stall = m_stall; e.flush = m_flush; e.err = m_err;
        sb.push_back(e);
        @(negedge clk);
        compare();
        @(posedge clk);
        if (rst) begin
            m_stall = 0; m_flush = 0; m_err = 1'b0;
        end else begin
            m_stall += int'(inc_s);
            m_flush += int'(inc_f);
        end
        #1;
    endtask

    task automatic clear_in();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        redirect = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_reg_write = 1'b1; mem_rd = 5'd7; ex_rs = 5'd7; mem_busy = 1'b1; set_lu();
        step("reset_hold", W1, FA, 2'b00, 2'b00, 0, 0);
        rst = 1'b0;
        clear_in();
        step("idle", W1, F0, 2'b00, 2'b00, 0, 0);

        set_lu();
        step("lu_c0", WLU, FLU, 2'b00, 2'b00, 1, 0);
        step("lu_c1", W1, F0, 2'b00, 2'b00, 0, 0);
        clear_in();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_rs = 5'd1; id_uses_rt = 1'b1;
        step("lu_rt", WLU, FLU, 2'b00, 2'b00, 1, 0);
        id_uses_rt = 1'b0;
        step("rt_unused", W1, F0, 2'b00, 2'b00, 0, 0);
        clear_in();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        step("lu_r0", W1, F0, 2'b00, 2'b00, 0, 0);

        clear_in();
        mem_reg_write = 1'b1; wb_reg_write = 1'b1; mem_rd = 5'd7; wb_rd = 5'd7;
        ex_rs = 5'd7; ex_rt = 5'd2;
        step("fwd_both", W1, F0, 2'b01, 2'b00, 0, 0);
        mem_rd = 5'd0; wb_rd = 5'd0; ex_rt = 5'd0; ex_rs = 5'd0;
        step("fwd_r0", W1, F0, 2'b00, 2'b00, 0, 0);
        mem_reg_write = 1'b0; mem_rd = 5'd3; wb_rd = 5'd3; ex_rt = 5'd3; ex_rs = 5'd4;
        step("fwd_wb", W1, F0, 2'b00, 2'b10, 0, 0);
        mem_reg_write = 1'b1; mem_rd = 5'd4;
        step("fwd_mix", W1, F0, 2'b01, 2'b10, 0, 0);

        clear_in();
        set_lu(); redirect = 1'b1;
        step("redir_lu", W1, FA, 2'b00, 2'b00, 0, 1);
        clear_in();
        step("post_redir", W1, F0, 2'b00, 2'b00, 0, 0);

        mem_busy = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd7; ex_rs = 5'd7;
        for (int i = 1; i <= 20; i++) begin
            redirect = (i == 10);
            step($sformatf("busy%0d", i), W0, F0, 2'b01, 2'b00, 1, 0);
            if (i >= 16) m_err = 1'b1;
        end
        mem_busy = 1'b0; redirect = 1'b1;
        step("release_redir", W1, FA, 2'b01, 2'b00, 0, 1);
        clear_in();
        step("after_release", W1, F0, 2'b00, 2'b00, 0, 0);
        mem_busy = 1'b1;
        step("busy_short", W0, F0, 2'b00, 2'b00, 1, 0);
        mem_busy = 1'b0; set_lu();
        step("release_lu", WLU, FLU, 2'b00, 2'b00, 1, 0);
        clear_in();
        step("idle2", W1, F0, 2'b00, 2'b00, 0, 0);

        mem_busy = 1'b1;
        step("pre_rst_busy0", W0, F0, 2'b00, 2'b00, 1, 0);
        step("pre_rst_busy1", W0, F0, 2'b00, 2'b00, 1, 0);
        rst = 1'b1; redirect = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd6; ex_rt = 5'd6;
        step("rst_mid", W1, FA, 2'b00, 2'b00, 0, 0);
        rst = 1'b0;
        clear_in();
        step("post_rst", W1, F0, 2'b00, 2'b00, 0, 0);
        set_lu();
        step("post_rst_lu", WLU, FLU, 2'b00, 2'b00, 1, 0);
        clear_in();
        step("post_rst_idle", W1, F0, 2'b00, 2'b00, 0, 0);

        for (int i = 0; i < 20; i++) begin
            set_lu();
            step($sformatf("sat_lu%0d", i), WLU, FLU, 2'b00, 2'b00, 1, 0);
            step($sformatf("sat_gap%0d", i), W1, F0, 2'b00, 2'b00, 0, 0);
        end
        clear_in();
        step("sat_end", W1, F0, 2'b00, 2'b00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
